// File: rtl/smoldvi_serialiser_mc.sv
// smoldvi_serialiser_mc: N_CHAN-lane symbol serialiser with a one-entry holding buffer, idle fill and sticky underflow.
// Optional PRBS7 lane pattern (prbs_en port) is built only when SMOLDVI_SER_PRBS_EN is defined.
module smoldvi_serialiser_mc #(
    parameter int               N_CHAN   = 3,
    parameter int               W_SYM    = 10,
    parameter int               W_OUT    = 2,
    parameter logic [W_SYM-1:0] IDLE_SYM = 10'h354
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CHAN*W_SYM-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_CHAN*W_OUT-1:0]  q_p,
    output logic [N_CHAN*W_OUT-1:0]  q_n,
    output logic                     sym_start,
    output logic                     underflow
`ifdef SMOLDVI_SER_PRBS_EN
    ,
    input  logic                     prbs_en
`endif
);

    localparam int                W_DATA    = N_CHAN * W_SYM;
    localparam int                W_Q       = N_CHAN * W_OUT;
    localparam int                BEATS     = W_SYM / W_OUT;
    localparam int                W_BEAT    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [W_BEAT-1:0] LAST_BEAT = W_BEAT'(BEATS - 1);

    logic [W_BEAT-1:0] r_beat;
    logic [W_DATA-1:0] r_buf;
    logic [W_DATA-1:0] r_sreg;
    logic [W_DATA-1:0] w_sreg_next;
    logic              r_buf_full;
    logic              r_in_ready;
    logic              r_primed;
    logic              r_underflow;
    logic              r_sym_start;
    logic [W_Q-1:0]    r_q_p;
    logic [W_Q-1:0]    r_q_n;
    logic [W_Q-1:0]    w_chunk;
    logic [W_Q-1:0]    w_q_next;
    logic              w_load;
    logic              w_accept;
    logic              w_buf_full_next;

    assign w_load          = (r_beat == LAST_BEAT);
    assign w_accept        = in_valid & r_in_ready;
    // A load empties the buffer; an accept can only happen when it is already empty.
    assign w_buf_full_next = w_accept | (r_buf_full & ~w_load);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_sreg_next = '0;
        w_chunk     = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            w_chunk[k*W_OUT +: W_OUT] = r_sreg[k*W_SYM +: W_OUT];
            if (w_load) begin
                w_sreg_next[k*W_SYM +: W_SYM] = r_buf_full ? r_buf[k*W_SYM +: W_SYM] : IDLE_SYM;
            end else begin
                w_sreg_next[k*W_SYM +: W_SYM] = r_sreg[k*W_SYM +: W_SYM] >> W_OUT;
            end
        end
    end

`ifdef SMOLDVI_SER_PRBS_EN
    logic [6:0]       r_prbs;
    logic [6:0]       w_prbs_next;
    logic [W_OUT-1:0] w_prbs_bits;

    // x^7+x^6+1, W_OUT steps per clock; the first bit generated lands on bit 0.
    always_comb begin
        w_prbs_next = r_prbs;
        w_prbs_bits = '0;
        for (int i = 0; i < W_OUT; i++) begin
            w_prbs_bits[i] = w_prbs_next[6] ^ w_prbs_next[5];
            w_prbs_next    = {w_prbs_next[5:0], w_prbs_bits[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prbs <= 7'h7f;
        end else begin
            r_prbs <= w_prbs_next;
        end
    end

    assign w_q_next = prbs_en ? {N_CHAN{w_prbs_bits}} : w_chunk;
`else
    assign w_q_next = w_chunk;
`endif

    // NOTE: the symbol buffer is pure datapath guarded by r_buf_full, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf <= in_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat      <= '0;
            r_buf_full  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_primed    <= 1'b0;
            r_underflow <= 1'b0;
            r_sreg      <= {N_CHAN{IDLE_SYM}};
            r_q_p       <= '0;
            r_q_n       <= '0;
            r_sym_start <= 1'b0;
        end else begin
            r_beat      <= w_load ? '0 : r_beat + W_BEAT'(1);
            r_buf_full  <= w_buf_full_next;
            r_in_ready  <= ~w_buf_full_next;
            if (w_accept) begin
                r_primed <= 1'b1;
            end
            // Starved load only counts once traffic has started.
            if (w_load && !r_buf_full && r_primed) begin
                r_underflow <= 1'b1;
            end
            r_sreg      <= w_sreg_next;
            r_q_p       <= w_q_next;
            r_q_n       <= ~w_q_next;
            r_sym_start <= (r_beat == '0);
        end
    end

    assign in_ready  = r_in_ready;
    assign q_p       = r_q_p;
    assign q_n       = r_q_n;
    assign sym_start = r_sym_start;
    assign underflow = r_underflow;

endmodule
